maze_solver_param: RTL

//  Parametrised NxN maze solver, next generation of the fixed 15x15 serial-input solver.
//  - Receives the maze one bit per cycle, then floods outward from the exit (all cells in parallel).
//  - Streams the shortest path from entrance (0,0) to exit (N-1,N-1), one coordinate per cycle.
//  - Flags an unsolvable maze with a one-cycle pulse instead of a path.

---
 rtl/maze_pkg.sv | 27 ++
 rtl/maze_flood_cell.sv | 67 ++++++
 rtl/maze_solver_param.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and helpers for the parametrised maze solver.
//   dir_e   : direction a reached cell points toward its parent (toward the exit)
//   state_e : solver FSM states
//   idx()   : row-major cell index, y*n + x
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_N = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlood,
    StTrace,
    StFail
  } state_e;

  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned n);
    return y * n + x;
  endfunction

endpackage

// File: rtl/maze_flood_cell.sv
// One cell of the flood array. Becomes "reached" when seeded (exit cell) or when
// flooding is enabled, the cell is open and any 4-neighbour is already reached.
// On becoming reached by flooding it latches the direction of a reached neighbour
// using the fixed priority E, S, W, N.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_wall         1 = wall, never reached
//   i_seed         force reached (exit cell, first flood cycle)
//   i_nbr_e/s/w/n  reached flags of the 4 neighbours (0 off-grid)
//   i_flood_en     allow growth this cycle
//   i_clear        clear reached/dir
//   o_reached      reached flag
//   o_dir          latched direction toward the exit
//   o_grow         this cell becomes reached at the next edge by flooding
module maze_flood_cell
  import maze_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_wall,
  input  logic i_seed,
  input  logic i_nbr_e,
  input  logic i_nbr_s,
  input  logic i_nbr_w,
  input  logic i_nbr_n,
  input  logic i_flood_en,
  input  logic i_clear,
  output logic o_reached,
  output dir_e o_dir,
  output logic o_grow
);

  logic r_reached;
  dir_e r_dir;
  dir_e w_dir_sel;
  logic w_grow;

  assign w_grow = i_flood_en & ~i_wall & ~r_reached & (i_nbr_e | i_nbr_s | i_nbr_w | i_nbr_n);

  always_comb begin
    w_dir_sel = DIR_N;
    if (i_nbr_e) begin
      w_dir_sel = DIR_E;
    end else if (i_nbr_s) begin
      w_dir_sel = DIR_S;
    end else if (i_nbr_w) begin
      w_dir_sel = DIR_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_reached <= 1'b0;
      r_dir     <= DIR_E;
    end else if (i_seed && !i_wall) begin
      r_reached <= 1'b1;
    end else if (w_grow) begin
      r_reached <= 1'b1;
      r_dir     <= w_dir_sel;
    end
  end

  assign o_reached = r_reached;
  assign o_dir     = r_dir;
  assign o_grow    = w_grow;

endmodule

// File: rtl/maze_solver_param.sv
// Parametrised NxN maze solver. Loads the maze serially (row-major, 1 = wall),
// floods outward from the exit (N-1,N-1) with all cells in parallel, then
// streams the shortest path from (0,0) to the exit one cell per cycle. An
// unsolvable maze produces a one-cycle maze_not_valid pulse instead.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid, maze  serial maze bit input
//   out_valid       out_x/out_y hold a path cell
//   maze_not_valid  one-cycle pulse: no path
//   out_x, out_y    path cell coordinates (0 when out_valid is low)
//   path_len        number of path cells while out_valid, else 0
//                   (only present when MAZE_PATH_LEN_EN is defined)
module maze_solver_param
  import maze_pkg::*;
#(
  parameter int unsigned N = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         maze,
  output logic                         out_valid,
  output logic                         maze_not_valid,
  output logic [$clog2(N)-1:0]         out_x,
`ifdef MAZE_PATH_LEN_EN
  output logic [$clog2(N*N+1)-1:0]     path_len,
`endif
  output logic [$clog2(N)-1:0]         out_y
);

  localparam int unsigned CW    = $clog2(N);
  localparam int unsigned CELLS = N * N;
  localparam int unsigned LW    = $clog2(CELLS + 1);
  localparam int unsigned IW    = $clog2(CELLS);

  state_e           r_state, w_state_next;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    r_fcnt;
  logic [CELLS-1:0] r_wall;
  logic [CW-1:0]    r_cur_x, r_cur_y;
  logic [CW-1:0]    w_cur_x_next, w_cur_y_next;
  logic [IW-1:0]    w_cur_idx;
  logic             w_clear, w_flood_first, w_seed, w_flood_en, w_at_exit, w_ends_walled;
  logic [CELLS-1:0] w_reached, w_grow;
  dir_e             w_dir [CELLS];

  logic             r_out_valid, r_mnv;
  logic [CW-1:0]    r_out_x, r_out_y;
  logic             w_out_valid_d, w_mnv_d;
  logic [CW-1:0]    w_out_x_d, w_out_y_d;

  // Flood control
  assign w_clear       = (r_state == StIdle) || (r_state == StLoad);
  assign w_flood_first = (r_state == StFlood) && (r_fcnt == '0);
  assign w_ends_walled = r_wall[0] || r_wall[CELLS-1];
  assign w_seed        = w_flood_first && !w_ends_walled;
  assign w_flood_en    = (r_state == StFlood) && !w_flood_first;

  // Cell array; off-grid neighbours are tied low so dir never points outside.
  for (genvar gy = 0; gy < N; gy++) begin : g_row
    for (genvar gx = 0; gx < N; gx++) begin : g_col
      localparam int unsigned I = idx(gx, gy, N);
      logic w_e, w_s, w_w, w_n;

      if (gx < N - 1) begin : g_e
        assign w_e = w_reached[I+1];
      end else begin : g_e_edge
        assign w_e = 1'b0;
      end
      if (gy < N - 1) begin : g_s
        assign w_s = w_reached[I+N];
      end else begin : g_s_edge
        assign w_s = 1'b0;
      end
      if (gx > 0) begin : g_w
        assign w_w = w_reached[I-1];
      end else begin : g_w_edge
        assign w_w = 1'b0;
      end
      if (gy > 0) begin : g_n
        assign w_n = w_reached[I-N];
      end else begin : g_n_edge
        assign w_n = 1'b0;
      end

      maze_flood_cell u_cell (
        .clk       (clk),
        .rst       (rst),
        .i_wall    (r_wall[I]),
        .i_seed    (w_seed & (I == CELLS - 1)),
        .i_nbr_e   (w_e),
        .i_nbr_s   (w_s),
        .i_nbr_w   (w_w),
        .i_nbr_n   (w_n),
        .i_flood_en(w_flood_en),
        .i_clear   (w_clear),
        .o_reached (w_reached[I]),
        .o_dir     (w_dir[I]),
        .o_grow    (w_grow[I])
      );
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) w_state_next = StLoad;
      end
      StLoad: begin
        if (in_valid && (r_cnt == LW'(CELLS - 1))) w_state_next = StFlood;
      end
      StFlood: begin
        if (w_flood_first) begin
          if (w_ends_walled) w_state_next = StFail;
        end else if (w_reached[0]) begin
          w_state_next = StTrace;
        end else if (!(|w_grow) || (r_fcnt == LW'(CELLS))) begin
          // Wavefront stalled without reaching the entrance
          w_state_next = StFail;
        end
      end
      StTrace: begin
        if (w_at_exit) w_state_next = StIdle;
      end
      StFail: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // FSM outputs (registered below)
  always_comb begin
    w_out_valid_d = (r_state == StTrace);
    w_mnv_d       = (r_state == StFail);
    w_out_x_d     = (r_state == StTrace) ? r_cur_x : '0;
    w_out_y_d     = (r_state == StTrace) ? r_cur_y : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_mnv       <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_mnv       <= w_mnv_d;
      r_out_x     <= w_out_x_d;
      r_out_y     <= w_out_y_d;
    end
  end

  // Trace pointer step along the latched direction of the current cell
  assign w_cur_idx = IW'(idx(32'(r_cur_x), 32'(r_cur_y), N));
  assign w_at_exit = (r_cur_x == CW'(N - 1)) && (r_cur_y == CW'(N - 1));

  always_comb begin
    w_cur_x_next = r_cur_x;
    w_cur_y_next = r_cur_y;
    unique case (w_dir[w_cur_idx])
      DIR_E: w_cur_x_next = r_cur_x + 1'b1;
      DIR_S: w_cur_y_next = r_cur_y + 1'b1;
      DIR_W: w_cur_x_next = r_cur_x - 1'b1;
      DIR_N: w_cur_y_next = r_cur_y - 1'b1;
    endcase
  end

  // Load shift register, counters and trace pointer. The shift register
  // places the first received bit at index 0 after CELLS shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wall  <= '0;
      r_fcnt  <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      if ((r_state == StIdle) || (r_state == StLoad)) begin
        if (in_valid) begin
          r_wall <= {maze, r_wall[CELLS-1:1]};
          r_cnt  <= (r_state == StIdle) ? LW'(1) : r_cnt + LW'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      r_fcnt <= (r_state == StFlood) ? r_fcnt + LW'(1) : '0;

      if (r_state == StTrace) begin
        r_cur_x <= w_cur_x_next;
        r_cur_y <= w_cur_y_next;
      end else begin
        r_cur_x <= '0;
        r_cur_y <= '0;
      end
    end
  end

`ifdef MAZE_PATH_LEN_EN
  // Wavefront counter: after the cycle that reaches distance d it holds d+1,
  // so it equals the path cell count once (0,0) is reached.
  logic [LW-1:0] r_wave, r_path_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wave     <= '0;
      r_path_len <= '0;
    end else begin
      if (w_flood_first) begin
        r_wave <= LW'(1);
      end else if ((r_state == StFlood) && !w_reached[0]) begin
        r_wave <= r_wave + LW'(1);
      end
      r_path_len <= (r_state == StTrace) ? r_wave : '0;
    end
  end

  assign path_len = r_path_len;
`endif

  assign out_valid      = r_out_valid;
  assign maze_not_valid = r_mnv;
  assign out_x          = r_out_x;
  assign out_y          = r_out_y;

endmodule
